// File: rtl/stopwatch_pkg.sv
// ============================================================================
// stopwatch_pkg : shared constants for the stopwatch timekeeping core
// Rev 1.0
// ============================================================================
`default_nettype none

package stopwatch_pkg;
  localparam int BCD_W         = 4;
  localparam int DIGIT_MAX_DEC = 9;
  localparam int DIGIT_MAX_SEX = 5;
  localparam int TICK_HZ       = 100;
  localparam int CLK_HZ        = 50_000_000;
  localparam int DIV_DEFAULT   = CLK_HZ / TICK_HZ;
endpackage

`default_nettype wire

// File: rtl/bcd_digit_counter.sv
// ============================================================================
// bcd_digit_counter : one BCD digit, wraps MAX->0, combinational carry-out
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = DIGIT_MAX_DEC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  localparam logic [BCD_W-1:0] MAX_Q = BCD_W'(MAX);

  // Carry is combinational so every digit of the chain advances on the same edge.
  assign carry = inc && (q == MAX_Q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == MAX_Q) ? '0 : q + BCD_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/stopwatch_counter.sv
// ============================================================================
// stopwatch_counter : 100 Hz prescaler plus six-digit BCD MM:SS.CC count
// Rev 1.0
// ============================================================================
`default_nettype none

module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  output logic [BCD_W-1:0] cs_u,
  output logic [BCD_W-1:0] cs_t,
  output logic [BCD_W-1:0] s_u,
  output logic [BCD_W-1:0] s_t,
  output logic [BCD_W-1:0] m_u,
  output logic [BCD_W-1:0] m_t,
  output logic             tick,
  output logic             wrapped
);

  localparam int                PRESC_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("stopwatch_counter: DIV must be at least 2");
  end

  logic [PRESC_W-1:0] presc;
  logic               inc_edge;
  logic               cy_cs_u, cy_cs_t, cy_s_u, cy_s_t, cy_m_u, cy_m_t;

  // Clear has priority: an increment edge that coincides with clear is dropped.
  assign inc_edge = enable && !clear && (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      tick    <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      tick <= inc_edge;
      if (clear) begin
        presc   <= '0;
        wrapped <= 1'b0;
      end else begin
        if (enable) begin
          presc <= inc_edge ? '0 : presc + PRESC_W'(1);
        end
        if (cy_m_t) begin
          wrapped <= 1'b1;
        end
      end
    end
  end

  bcd_digit_counter #(.MAX(DIGIT_MAX_DEC)) u_cs_u (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(inc_edge), .q(cs_u), .carry(cy_cs_u)
  );
  bcd_digit_counter #(.MAX(DIGIT_MAX_DEC)) u_cs_t (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(cy_cs_u), .q(cs_t), .carry(cy_cs_t)
  );
  bcd_digit_counter #(.MAX(DIGIT_MAX_DEC)) u_s_u (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(cy_cs_t), .q(s_u), .carry(cy_s_u)
  );
  bcd_digit_counter #(.MAX(DIGIT_MAX_SEX)) u_s_t (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(cy_s_u), .q(s_t), .carry(cy_s_t)
  );
  bcd_digit_counter #(.MAX(DIGIT_MAX_DEC)) u_m_u (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(cy_s_t), .q(m_u), .carry(cy_m_u)
  );
  bcd_digit_counter #(.MAX(DIGIT_MAX_SEX)) u_m_t (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(cy_m_u), .q(m_t), .carry(cy_m_t)
  );

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
// ============================================================================
// tb_stopwatch_counter : table-driven check of stopwatch_counter with DIV=4
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_counter;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       clear;
  logic [3:0] cs_u, cs_t, s_u, s_t, m_u, m_t;
  logic       tick;
  logic       wrapped;
  logic [23:0] now_t;

  int compared = 0;
  int failed   = 0;

  stopwatch_counter #(.DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .cs_u(cs_u), .cs_t(cs_t), .s_u(s_u), .s_t(s_t), .m_u(m_u), .m_t(m_t),
    .tick(tick), .wrapped(wrapped)
  );

  assign now_t = {m_t, m_u, s_t, s_u, cs_t, cs_u};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        clr;
    int          n;
    logic [23:0] t;
    logic        tk;
    logic        wr;
    int          ps;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [23:0] t, input logic tk,
                       input logic wr, input int ps);
    int act_ps;
    act_ps = int'(dut.presc);
    compared++;
    if (now_t !== t || tick !== tk || wrapped !== wr || act_ps != ps) begin
      failed++;
      $display("FAIL %s: got time=%h tick=%b wrapped=%b presc=%0d, expected time=%h tick=%b wrapped=%b presc=%0d",
               name, now_t, tick, wrapped, act_ps, t, tk, wr, ps);
    end
  endtask

  // Drive inputs for n rising edges, then sample on the following falling edge.
  task automatic step(input logic en, input logic clr, input int n);
    enable = en;
    clear  = clr;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Deposit a digit pattern between edges; released values persist until the next edge.
  task automatic preload(input logic [23:0] v);
    force dut.u_m_t.q  = v[23:20];
    force dut.u_m_u.q  = v[19:16];
    force dut.u_s_t.q  = v[15:12];
    force dut.u_s_u.q  = v[11:8];
    force dut.u_cs_t.q = v[7:4];
    force dut.u_cs_u.q = v[3:0];
    #1;
    release dut.u_m_t.q;
    release dut.u_m_u.q;
    release dut.u_s_t.q;
    release dut.u_s_u.q;
    release dut.u_cs_t.q;
    release dut.u_cs_u.q;
    #1;
  endtask

  initial begin
    //            en    clr   n   time        tick  wrap  presc
    vecs[0]  = '{1'b1, 1'b0, 3,  24'h000000, 1'b0, 1'b0, 3};
    vecs[1]  = '{1'b1, 1'b0, 1,  24'h000001, 1'b1, 1'b0, 0};
    vecs[2]  = '{1'b1, 1'b0, 8,  24'h000003, 1'b1, 1'b0, 0};
    vecs[3]  = '{1'b1, 1'b0, 2,  24'h000003, 1'b0, 1'b0, 2};
    vecs[4]  = '{1'b0, 1'b0, 10, 24'h000003, 1'b0, 1'b0, 2};
    vecs[5]  = '{1'b1, 1'b0, 1,  24'h000003, 1'b0, 1'b0, 3};
    vecs[6]  = '{1'b1, 1'b0, 1,  24'h000004, 1'b1, 1'b0, 0};
    vecs[7]  = '{1'b1, 1'b0, 3,  24'h000004, 1'b0, 1'b0, 3};
    vecs[8]  = '{1'b0, 1'b0, 3,  24'h000004, 1'b0, 1'b0, 3};
    vecs[9]  = '{1'b1, 1'b0, 1,  24'h000005, 1'b1, 1'b0, 0};
    vecs[10] = '{1'b1, 1'b0, 3,  24'h000005, 1'b0, 1'b0, 3};
    vecs[11] = '{1'b1, 1'b1, 1,  24'h000000, 1'b0, 1'b0, 0};
    vecs[12] = '{1'b1, 1'b0, 3,  24'h000000, 1'b0, 1'b0, 3};
    vecs[13] = '{1'b1, 1'b0, 1,  24'h000001, 1'b1, 1'b0, 0};
    vecs[14] = '{1'b1, 1'b0, 2,  24'h000001, 1'b0, 1'b0, 2};
    vecs[15] = '{1'b0, 1'b1, 1,  24'h000000, 1'b0, 1'b0, 0};
    vecs[16] = '{1'b0, 1'b0, 3,  24'h000000, 1'b0, 1'b0, 0};

    rst_n  = 1'b0;
    enable = 1'b0;
    clear  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", 24'h000000, 1'b0, 1'b0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].en, vecs[i].clr, vecs[i].n);
      check($sformatf("vec%0d", i), vecs[i].t, vecs[i].tk, vecs[i].wr, vecs[i].ps);
    end

    // Seconds-tens carry: 00:09.99 -> 00:10.00
    preload(24'h000999);
    step(1'b1, 1'b0, 3);
    check("pre_sec_carry", 24'h000999, 1'b0, 1'b0, 3);
    step(1'b1, 1'b0, 1);
    check("sec_carry", 24'h001000, 1'b1, 1'b0, 0);

    // Minutes-tens carry: 09:59.99 -> 10:00.00
    enable = 1'b0;
    preload(24'h095999);
    step(1'b1, 1'b0, 3);
    check("pre_min_carry", 24'h095999, 1'b0, 1'b0, 3);
    step(1'b1, 1'b0, 1);
    check("min_carry", 24'h100000, 1'b1, 1'b0, 0);

    // Full rollover and sticky wrapped
    enable = 1'b0;
    preload(24'h595999);
    step(1'b1, 1'b0, 3);
    check("pre_rollover", 24'h595999, 1'b0, 1'b0, 3);
    step(1'b1, 1'b0, 1);
    check("rollover", 24'h000000, 1'b1, 1'b1, 0);
    step(1'b1, 1'b0, 8);
    check("wrapped_sticky", 24'h000002, 1'b1, 1'b1, 0);

    // Asynchronous reset between edges at 00:12.34 while wrapped is set
    enable = 1'b0;
    preload(24'h001234);
    step(1'b1, 1'b0, 2);
    check("pre_async_rst", 24'h001234, 1'b0, 1'b1, 2);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst", 24'h000000, 1'b0, 1'b0, 0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_restart", 24'h000000, 1'b0, 1'b0, 1);
    step(1'b1, 1'b0, 3);
    check("post_rst_first_tick", 24'h000001, 1'b1, 1'b0, 0);

    // Clear drops a set wrapped flag
    enable = 1'b0;
    preload(24'h595999);
    step(1'b1, 1'b0, 4);
    check("rollover2", 24'h000000, 1'b1, 1'b1, 0);
    step(1'b1, 1'b0, 2);
    step(1'b1, 1'b1, 1);
    check("clear_wrapped", 24'h000000, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 4);
    check("after_clear_tick", 24'h000001, 1'b1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

`default_nettype wire
